// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: 8N1 framing, or 8 data + parity + 1 stop when UART_TX_PARITY_EN is defined.
// Bit time is (baud_div+1)*OSR clocks; tx comes straight from a flop.
module uart_tx_ctrl #(
  parameter int DIV_W = 16,
  parameter int OSR   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             parity_odd,
  output logic             tx,
  output logic             busy
);

  localparam int OSW = (OSR > 1) ? $clog2(OSR) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  state_t           state_q, state_d;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [OSW-1:0]   os_cnt_q, os_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             tick, bit_end;

  // >= rather than == so a divisor lowered below the running count still wraps at once
  assign tick    = (tick_cnt_q >= baud_div);
  assign bit_end = tick && (os_cnt_q == OSW'(OSR - 1));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    tx_d       = tx_q;
    if (state_q == IDLE) begin
      tx_d = 1'b1;
      if (tx_valid) begin
        data_d     = tx_data;
        tick_cnt_d = '0;
        os_cnt_d   = '0;
        bit_idx_d  = '0;
        state_d    = START;
        tx_d       = 1'b0;
      end
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) os_cnt_d = bit_end ? '0 : os_cnt_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          START: begin
            state_d   = DATA;
            bit_idx_d = '0;
            tx_d      = data_q[0];
          end
          DATA: begin
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = (^data_q) ^ parity_odd;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              tx_d      = data_q[bit_idx_q + 3'd1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
`endif
          STOP: begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
          default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: checks the first and last clock of every bit plus the ready edge.
module tb_uart_tx_ctrl;
  localparam int DIV_W = 16;
  localparam int OSR   = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [DIV_W-1:0] baud_div;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             parity_odd;
  logic             tx_ready;
  logic             tx;
  logic             busy;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DIV_W(DIV_W), .OSR(OSR)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_div   (baud_div),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_odd (parity_odd),
    .tx         (tx),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge while IDLE; returns #1 after the handshake edge.
  task automatic handshake(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    chk("ready_before_hs", tx_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Expects to start #1 after the handshake edge; ends at the negedge of the first IDLE cycle.
  task automatic check_frame(input string nm, input logic [7:0] d, input int div);
    int   len;
    logic exp_bits [NB];
    len = (div + 1) * OSR;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[9] = (^d) ^ parity_odd;
`endif
    exp_bits[NB-1] = 1'b1;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      chk($sformatf("%s bit%0d first", nm, k), tx, exp_bits[k]);
      chk($sformatf("%s bit%0d busy", nm, k), busy, 1'b1);
      repeat (len - 1) @(negedge clk);
      chk($sformatf("%s bit%0d last", nm, k), tx, exp_bits[k]);
    end
    chk({nm, " ready_still_low"}, tx_ready, 1'b0);
    @(negedge clk);
    chk({nm, " ready_back"}, tx_ready, 1'b1);
    chk({nm, " idle_busy"}, busy, 1'b0);
    chk({nm, " idle_tx"}, tx, 1'b1);
  endtask

  initial begin
    reset_n    = 1'b0;
    baud_div   = '0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    parity_odd = 1'b0;
    #12;
    chk("reset tx", tx, 1'b1);
    chk("reset ready", tx_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 0x55 at full rate, data bus scrambled after capture
    handshake(8'h55);
    tx_valid = 1'b0;
    tx_data  = 8'hAA;
    check_frame("f55", 8'h55, 0);
    repeat (5) @(negedge clk);
    chk("idle tx", tx, 1'b1);
    chk("idle ready", tx_ready, 1'b1);

    // 0x01 with 64-clock bits
    @(posedge clk);
    #1;
    baud_div = 16'd3;
    handshake(8'h01);
    tx_valid = 1'b0;
    tx_data  = 8'hFE;
    check_frame("f01", 8'h01, 3);

`ifdef UART_TX_PARITY_EN
    // 0x07 has odd weight: even parity bit 1, odd parity bit 0
    @(posedge clk);
    #1;
    baud_div   = '0;
    parity_odd = 1'b0;
    handshake(8'h07);
    tx_valid = 1'b0;
    check_frame("f07even", 8'h07, 0);
    @(posedge clk);
    #1;
    parity_odd = 1'b1;
    handshake(8'h07);
    tx_valid = 1'b0;
    check_frame("f07odd", 8'h07, 0);
    parity_odd = 1'b0;
`endif

    // back-to-back with tx_valid held high
    @(posedge clk);
    #1;
    baud_div = '0;
    handshake(8'hA5);
    tx_data = 8'h3C;
    check_frame("fA5", 8'hA5, 0);
    @(posedge clk);
    #1;
    tx_data = 8'h11;
    check_frame("f3C", 8'h3C, 0);
    tx_valid = 1'b0;

    // reset pulse in the middle of data bit 4 (a 0 bit for 0xEF)
    @(posedge clk);
    #1;
    handshake(8'hEF);
    tx_valid = 1'b0;
    repeat (5 * OSR + OSR / 2) @(negedge clk);
    chk("pre_reset tx", tx, 1'b0);
    chk("pre_reset busy", busy, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort tx", tx, 1'b1);
    chk("abort ready", tx_ready, 1'b1);
    chk("abort busy", busy, 1'b0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    handshake(8'hC3);
    tx_valid = 1'b0;
    check_frame("fC3", 8'hC3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
